// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Default widths, RA register index, write request bundle, arbiter FSM states.
package wb_port_arbiter_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int RA_REG = 15;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req;

  typedef enum logic {
    NORMAL,
    FORCE
  } arb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Multi-cycle result FIFO with per-entry live bit and kill-by-address.
// Ports: push/pop, kill, head fields, empty/full, mask of live destinations.
module wb_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [ADDR_W-1:0]    pushAddr,
  input  logic [DATA_W-1:0]    pushData,
  input  logic                 pop,
  input  logic                 killEn,
  input  logic [ADDR_W-1:0]    killAddr,
  output logic [ADDR_W-1:0]    headAddr,
  output logic [DATA_W-1:0]    headData,
  output logic                 headLive,
  output logic                 empty,
  output logic                 full,
  output logic [2**ADDR_W-1:0] liveMask
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

  logic [IW:0]       wrPtr;
  logic [IW:0]       rdPtr;
  logic [IW-1:0]     wrIdx;
  logic [IW-1:0]     rdIdx;
  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [DEPTH-1:0]  live;
  logic              doPush;
  logic              doPop;

  assign wrIdx  = wrPtr[IW-1:0];
  assign rdIdx  = rdPtr[IW-1:0];
  assign empty  = wrPtr == rdPtr;
  assign full   = (wrIdx == rdIdx) &&
                  (wrPtr[IW] != rdPtr[IW]);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  assign headAddr = addrMem[rdIdx];
  assign headData = dataMem[rdIdx];
  // Live bits are only ever set on occupied slots.
  assign headLive = live[rdIdx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      live  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (killEn && addrMem[i] == killAddr) begin
          live[i] <= 1'b0;
        end
      end
      if (doPop) begin
        live[rdIdx] <= 1'b0;
        rdPtr       <= rdPtr + PTR_ONE;
      end
      // Same-cycle enqueue survives a kill to its address.
      if (doPush) begin
        live[wrIdx] <= 1'b1;
        wrPtr       <= wrPtr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      addrMem[wrIdx] <= pushAddr;
      dataMem[wrIdx] <= pushData;
    end
  end

  always_comb begin
    liveMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) begin
        liveMask[addrMem[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the RW stage and a
// multi-cycle result FIFO, with bounded-wait forced stall and WAW kill.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_valid,
  input  logic [ADDR_W-1:0]    pipe_addr,
  input  logic [DATA_W-1:0]    pipe_data,
  output logic                 pipe_stall,
  input  logic                 mc_valid,
  input  logic [ADDR_W-1:0]    mc_addr,
  input  logic [DATA_W-1:0]    mc_data,
  output logic                 mc_ready,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] pend_mask
);

  import wb_port_arbiter_pkg::arb_state_e;
  import wb_port_arbiter_pkg::NORMAL;
  import wb_port_arbiter_pkg::FORCE;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_state_e        state;
  arb_state_e        stateNext;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cntNext;
  logic [CW-1:0]     cntInc;

  logic              popHead;
  logic              killEn;
  logic              grantWe;
  logic [ADDR_W-1:0] grantAddr;
  logic [DATA_W-1:0] grantData;

  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;
  logic              headLive;
  logic              empty;
  logic              full;

  wb_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (mc_valid),
    .pushAddr (mc_addr),
    .pushData (mc_data),
    .pop      (popHead),
    .killEn   (killEn),
    .killAddr (pipe_addr),
    .headAddr (headAddr),
    .headData (headData),
    .headLive (headLive),
    .empty    (empty),
    .full     (full),
    .liveMask (pend_mask)
  );

  assign mc_ready   = !full;
  assign pipe_stall = state == FORCE;
  assign cntInc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_comb begin
    popHead   = 1'b0;
    killEn    = 1'b0;
    grantWe   = 1'b0;
    grantAddr = '0;
    grantData = '0;
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      NORMAL: begin
        if (pipe_valid) begin
          grantWe   = 1'b1;
          grantAddr = pipe_addr;
          grantData = pipe_data;
          killEn    = 1'b1;
          // Only a live head can starve; a dead one just waits.
          if (headLive) begin
            cntNext = cntInc;
            if (cntInc == CNT_MAX) begin
              stateNext = FORCE;
            end
          end
        end else if (!empty) begin
          popHead   = 1'b1;
          grantWe   = headLive;
          grantAddr = headAddr;
          grantData = headData;
          cntNext   = '0;
        end
      end
      FORCE: begin
        stateNext = NORMAL;
        cntNext   = '0;
        if (!empty) begin
          popHead   = 1'b1;
          grantWe   = headLive;
          grantAddr = headAddr;
          grantData = headData;
        end
      end
      default: begin
        stateNext = NORMAL;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      cnt      <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      rf_we <= grantWe;
      if (grantWe) begin
        rf_waddr <= grantAddr;
        rf_wdata <= grantData;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk;
  logic          rst_n;
  logic          pipe_valid;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          pipe_stall;
  logic          mc_valid;
  logic [AW-1:0] mc_addr;
  logic [DW-1:0] mc_data;
  logic          mc_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [15:0]   pend_mask;

  int checks;
  int failures;

  wb_port_arbiter #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_valid (pipe_valid),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .pipe_stall (pipe_stall),
    .mc_valid   (mc_valid),
    .mc_addr    (mc_addr),
    .mc_data    (mc_data),
    .mc_ready   (mc_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pend_mask  (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: buffered results as parallel queues.
  logic [AW-1:0] qa[$];
  logic [DW-1:0] qd[$];
  bit            ql[$];
  int            waited;
  bit            forceNext;
  bit            expWe;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expData;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    qa.delete();
    qd.delete();
    ql.delete();
    waited    = 0;
    forceNext = 0;
    expWe     = 0;
  endtask

  task automatic popModel();
    expWe   = ql[0];
    expAddr = qa[0];
    expData = qd[0];
    void'(qa.pop_front());
    void'(qd.pop_front());
    void'(ql.pop_front());
    waited = 0;
  endtask

  // Called at the active edge with the inputs that were sampled there.
  task automatic modelStep();
    bit            acc;
    logic [AW-1:0] na;
    logic [DW-1:0] nd;
    acc   = mc_valid && (qa.size() < DEPTH);
    na    = mc_addr;
    nd    = mc_data;
    expWe = 0;
    if (forceNext) begin
      forceNext = 0;
      if (qa.size() > 0) popModel();
      waited = 0;
    end else if (pipe_valid) begin
      expWe   = 1;
      expAddr = pipe_addr;
      expData = pipe_data;
      if (qa.size() > 0 && ql[0]) begin
        if (waited < LIMIT) waited++;
        if (waited == LIMIT) forceNext = 1;
      end
      foreach (qa[i]) if (qa[i] == pipe_addr) ql[i] = 0;
    end else if (qa.size() > 0) begin
      popModel();
    end
    if (acc) begin
      qa.push_back(na);
      qd.push_back(nd);
      ql.push_back(1);
    end
  endtask

  task automatic checkAll();
    logic [15:0] m;
    m = '0;
    foreach (qa[i]) if (ql[i]) m[qa[i]] = 1'b1;
    check("pipe_stall", pipe_stall, forceNext);
    check("mc_ready", mc_ready, qa.size() < DEPTH);
    check("pend_mask", pend_mask, m);
    check("rf_we", rf_we, expWe);
    if (expWe) begin
      check("rf_waddr", rf_waddr, expAddr);
      check("rf_wdata", rf_wdata, expData);
    end
  endtask

  task automatic drive(input bit pv, input logic [AW-1:0] pa,
                       input logic [DW-1:0] pd, input bit mv,
                       input logic [AW-1:0] ma, input logic [DW-1:0] md);
    pipe_valid = pv;
    pipe_addr  = pa;
    pipe_data  = pd;
    mc_valid   = mv;
    mc_addr    = ma;
    mc_data    = md;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int  stalls;
    int  budget;
    bit  rmv;
    logic [AW-1:0] rma;
    logic [DW-1:0] rmd;
    bit  acc;

    checks     = 0;
    failures   = 0;
    pipe_valid = 0;
    pipe_addr  = 0;
    pipe_data  = 0;
    mc_valid   = 0;
    mc_addr    = 0;
    mc_data    = 0;
    rst_n      = 1;
    modelReset();
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_stall", pipe_stall, 0);
    check("rst_mc_ready", mc_ready, 1);
    check("rst_pend", pend_mask, 0);
    @(negedge clk);
    rst_n = 1;

    // Pipe only
    drive(1, 3, 32'h11, 0, 0, 0);
    check("pipe_waddr", rf_waddr, 3);
    check("pipe_wdata", rf_wdata, 32'h11);
    check("pipe_pend", pend_mask, 0);
    idle(1);

    // Idle-slot drain
    drive(0, 0, 0, 1, 5, 32'hAB);
    check("drain_pend", pend_mask, 16'h0020);
    drive(0, 0, 0, 0, 0, 0);
    check("drain_we", rf_we, 1);
    check("drain_waddr", rf_waddr, 5);
    check("drain_wdata", rf_wdata, 32'hAB);
    check("drain_pend0", pend_mask, 0);

    // Starvation
    drive(1, 1, 32'h1000, 1, 9, 32'hC0DE);
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 32'h1001 + i, 0, 0, 0);
      if (pipe_stall) stalls++;
    end
    check("starve_stalls", stalls, 1);
    idle(2);

    // Full / backpressure
    drive(1, 2, 32'h2000, 1, 4, 32'h100);
    drive(1, 2, 32'h2001, 1, 6, 32'h200);
    check("full_ready", mc_ready, 0);
    budget = 0;
    acc    = 0;
    while (!acc && budget < 20) begin
      acc = mc_ready;
      drive(1, 2, 32'h2100 + budget, 1, 8, 32'h300);
      budget++;
    end
    check("full_accept", acc, 1);
    idle(5);

    // WAW kill
    drive(1, 1, 32'h3000, 1, 7, 32'h77);
    check("waw_pend", pend_mask, 16'h0080);
    drive(1, 7, 32'h22, 0, 0, 0);
    check("waw_kill", pend_mask, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("waw_nowrite", rf_we, 0);
    idle(2);

    // Reset mid-operation in FORCE with full FIFO
    drive(1, 1, 32'h4000, 1, 10, 32'hA0);
    drive(1, 1, 32'h4001, 1, 11, 32'hB0);
    budget = 0;
    while (!pipe_stall && budget < 10) begin
      drive(1, 1, 32'h4002 + budget, 0, 0, 0);
      budget++;
    end
    check("mid_force", pipe_stall, 1);
    check("mid_full", mc_ready, 0);
    #2 rst_n = 0;
    #1;
    check("mid_stall", pipe_stall, 0);
    check("mid_we", rf_we, 0);
    check("mid_ready", mc_ready, 1);
    check("mid_pend", pend_mask, 0);
    modelReset();
    pipe_valid = 0;
    @(posedge clk);
    #2 rst_n = 1;
    idle(4);

    // Randomized traffic
    rmv = 0;
    rma = 0;
    rmd = 0;
    for (int i = 0; i < 400; i++) begin
      acc = rmv && mc_ready;
      if (!rmv || acc) begin
        rmv = ($urandom_range(0, 99) < 45);
        rma = AW'($urandom_range(0, 15));
        rmd = $urandom;
      end
      drive($urandom_range(0, 99) < 70, AW'($urandom_range(0, 15)),
            $urandom, rmv, rma, rmd);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
